// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers, exception-type encodings, ExcCode values and
// Status/Cause field positions shared by the CP0 exception controller.
`default_nettype none

package cp0_pkg;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_REG_EPC     = 5'd14;
    localparam logic [4:0] CP0_REG_PRID    = 5'd15;

    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_RI      = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    localparam logic [4:0] EXCCODE_INT     = 5'd0;
    localparam logic [4:0] EXCCODE_SYS     = 5'd8;
    localparam logic [4:0] EXCCODE_RI      = 5'd10;
    localparam logic [4:0] EXCCODE_OV      = 5'd12;
    localparam logic [4:0] EXCCODE_TR      = 5'd13;
    localparam logic [4:0] EXCCODE_UNKNOWN = 5'h1f;

    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int STATUS_IM_LSB  = 8;
    localparam int STATUS_IM_MSB  = 15;
    localparam int CAUSE_EXC_LSB  = 2;
    localparam int CAUSE_EXC_MSB  = 6;
    localparam int CAUSE_IP_LSB   = 8;
    localparam int CAUSE_IP_MSB   = 15;
    localparam int CAUSE_BD_BIT   = 31;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } cp0_state_t;

    function automatic logic [4:0] exc_code_lookup(input logic [31:0] exc_type);
        logic [4:0] code;
        case (exc_type)
            EXC_INT:     code = EXCCODE_INT;
            EXC_SYSCALL: code = EXCCODE_SYS;
            EXC_RI:      code = EXCCODE_RI;
            EXC_OV:      code = EXCCODE_OV;
            EXC_TRAP:    code = EXCCODE_TR;
            default:     code = EXCCODE_UNKNOWN;
        endcase
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_timer.sv
// cp0_timer: free-running Count, Compare and the sticky timer-interrupt flag.
// Instantiated only when CP0_TIMER_EN is defined.
`default_nettype none

module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 32'h0;
            compare   <= 32'h0;
            timer_int <= 1'b0;
        end else begin
            count <= count_we ? wdata : count + 32'h1;
            if (compare_we) begin
                compare <= wdata;
            end
            // A Compare write acknowledges the interrupt and beats a same-cycle match.
            if (compare_we) begin
                timer_int <= 1'b0;
            end else if ((count == compare) && (compare != 32'h0)) begin
                timer_int <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: CP0 register file and exception commit engine with flush/redirect.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
`default_nettype none

module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter logic [31:0] PRID_VAL   = 32'h0042_0001,
    parameter logic [31:0] STATUS_RST = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exception_en,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_next_i,
    input  logic        is_slot_i,
    input  logic [5:0]  int_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    cp0_state_t  state;
    cp0_state_t  state_next;
    logic        commit;

    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic [7:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;
    logic [31:0] new_pc;

    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_int;
    logic        ip7_src;

`ifdef CP0_TIMER_EN
    logic unused_int5;
    assign unused_int5 = int_i[5];

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (we_i && (waddr_i == CP0_REG_COUNT)),
        .compare_we (we_i && (waddr_i == CP0_REG_COMPARE)),
        .wdata      (wdata_i),
        .count      (count),
        .compare    (compare),
        .timer_int  (timer_int)
    );
    assign ip7_src = timer_int;
`else
    assign count     = 32'h0;
    assign compare   = 32'h0;
    assign timer_int = 1'b0;
    assign ip7_src   = int_i[5];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        flush_o    = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (exception_en) begin
                    commit     = 1'b1;
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush_o    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // WB write first; exception fields assigned later in the block override it.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_im  <= STATUS_RST[STATUS_IM_MSB:STATUS_IM_LSB];
            status_exl <= STATUS_RST[STATUS_EXL_BIT];
            status_ie  <= STATUS_RST[STATUS_IE_BIT];
            cause_bd   <= 1'b0;
            cause_ip   <= 8'h0;
            cause_exc  <= 5'h0;
            epc        <= 32'h0;
            new_pc     <= 32'h0;
        end else begin
            cause_ip[7:2] <= {ip7_src, int_i[4:0]};
            if (we_i) begin
                case (waddr_i)
                    CP0_REG_STATUS: begin
                        status_im  <= wdata_i[STATUS_IM_MSB:STATUS_IM_LSB];
                        status_exl <= wdata_i[STATUS_EXL_BIT];
                        status_ie  <= wdata_i[STATUS_IE_BIT];
                    end
                    CP0_REG_CAUSE: cause_ip[1:0] <= wdata_i[CAUSE_IP_LSB+1:CAUSE_IP_LSB];
                    CP0_REG_EPC:   epc <= wdata_i;
                    default: ;
                endcase
            end
            if (commit) begin
                if (excepttype_i == EXC_ERET) begin
                    status_exl <= 1'b0;
                    new_pc     <= epc;
                end else begin
                    if (!status_exl) begin
                        epc      <= pc_next_i;
                        cause_bd <= is_slot_i;
                    end
                    status_exl <= 1'b1;
                    cause_exc  <= exc_code_lookup(excepttype_i);
                    new_pc     <= EXC_VECTOR;
                end
            end
        end
    end

    always_comb begin
        status_o = STATUS_RST;
        status_o[STATUS_IM_MSB:STATUS_IM_LSB] = status_im;
        status_o[STATUS_EXL_BIT] = status_exl;
        status_o[STATUS_IE_BIT]  = status_ie;
        cause_o = 32'h0;
        cause_o[CAUSE_BD_BIT] = cause_bd;
        cause_o[CAUSE_IP_MSB:CAUSE_IP_LSB]   = cause_ip;
        cause_o[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = cause_exc;
    end

    always_comb begin
        rdata_o = 32'h0;
        case (raddr_i)
            CP0_REG_COUNT:   rdata_o = count;
            CP0_REG_COMPARE: rdata_o = compare;
            CP0_REG_STATUS:  rdata_o = status_o;
            CP0_REG_CAUSE:   rdata_o = cause_o;
            CP0_REG_EPC:     rdata_o = epc;
            CP0_REG_PRID:    rdata_o = PRID_VAL;
            default:         rdata_o = 32'h0;
        endcase
    end

    assign epc_o       = epc;
    assign timer_int_o = timer_int;
    assign new_pc_o    = new_pc;

endmodule

`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: register-map vector table, directed exception/timer
// sequences and randomized traffic against a word-level CP0 model.
`default_nettype none

module tb_cp0_exc_ctrl;

    localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;
    localparam logic [31:0] PRID_VAL   = 32'h0042_0001;
    localparam logic [31:0] STATUS_RST = 32'h1000_0000;
    localparam logic [31:0] SMASK      = 32'h0000_FF03;
    localparam logic [31:0] CMASK      = 32'h0000_0300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exception_en = 1'b0;
    logic [31:0] excepttype_i = 32'h0;
    logic [31:0] pc_next_i = 32'h0;
    logic        is_slot_i = 1'b0;
    logic [5:0]  int_i = 6'h0;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = 5'h0;
    logic [31:0] wdata_i = 32'h0;
    logic [4:0]  raddr_i = 5'h0;
    logic [31:0] rdata_o, status_o, cause_o, epc_o, new_pc_o;
    logic        timer_int_o, flush_o;

    int checks = 0;
    int failures = 0;

    cp0_exc_ctrl #(
        .EXC_VECTOR (EXC_VECTOR),
        .PRID_VAL   (PRID_VAL),
        .STATUS_RST (STATUS_RST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .exception_en (exception_en),
        .excepttype_i (excepttype_i),
        .pc_next_i    (pc_next_i),
        .is_slot_i    (is_slot_i),
        .int_i        (int_i),
        .we_i         (we_i),
        .waddr_i      (waddr_i),
        .wdata_i      (wdata_i),
        .raddr_i      (raddr_i),
        .rdata_o      (rdata_o),
        .status_o     (status_o),
        .cause_o      (cause_o),
        .epc_o        (epc_o),
        .timer_int_o  (timer_int_o),
        .flush_o      (flush_o),
        .new_pc_o     (new_pc_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Architectural model state: whole 32-bit register words.
    logic [31:0] m_status, m_cause, m_epc, m_count, m_compare, m_newpc;
    logic        m_tint, m_flush;
    logic [31:0] n_status, n_cause, n_epc, n_count, n_compare, n_newpc;
    logic        n_tint, n_flush;

    function automatic logic [4:0] ref_code(input logic [31:0] t);
        case (t)
            32'h1:   return 5'd0;
            32'h8:   return 5'd8;
            32'ha:   return 5'd10;
            32'hc:   return 5'd12;
            32'hd:   return 5'd13;
            default: return 5'h1f;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID_VAL;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        logic ip7;
        if (rst) begin
            n_status = STATUS_RST; n_cause = 0; n_epc = 0; n_count = 0;
            n_compare = 0; n_newpc = 0; n_tint = 0; n_flush = 0;
            return;
        end
        n_status = m_status; n_cause = m_cause; n_epc = m_epc; n_newpc = m_newpc;
`ifdef CP0_TIMER_EN
        n_count   = (we_i && waddr_i == 5'd9) ? wdata_i : m_count + 1;
        n_compare = (we_i && waddr_i == 5'd11) ? wdata_i : m_compare;
        n_tint    = (we_i && waddr_i == 5'd11) ? 1'b0
                  : (m_tint || (m_count == m_compare && m_compare != 0));
        ip7 = m_tint;
`else
        n_count = 0; n_compare = 0; n_tint = 0;
        ip7 = int_i[5];
`endif
        n_cause[15:10] = {ip7, int_i[4:0]};
        if (we_i) begin
            if (waddr_i == 5'd12) n_status = (STATUS_RST & ~SMASK) | (wdata_i & SMASK);
            if (waddr_i == 5'd13) n_cause = (n_cause & ~CMASK) | (wdata_i & CMASK);
            if (waddr_i == 5'd14) n_epc = wdata_i;
        end
        n_flush = !m_flush && exception_en;
        if (n_flush) begin
            if (excepttype_i == 32'he) begin
                n_status[1] = 1'b0;
                n_newpc = m_epc;
            end else begin
                if (!m_status[1]) begin
                    n_epc = pc_next_i;
                    n_cause[31] = is_slot_i;
                end
                n_status[1] = 1'b1;
                n_cause[6:2] = ref_code(excepttype_i);
                n_newpc = EXC_VECTOR;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_count = n_count;
        m_compare = n_compare; m_newpc = n_newpc; m_tint = n_tint; m_flush = n_flush;
        check("m_status", status_o, m_status);
        check("m_cause", cause_o, m_cause);
        check("m_epc", epc_o, m_epc);
        check("m_timer", {31'h0, timer_int_o}, {31'h0, m_tint});
        check("m_flush", {31'h0, flush_o}, {31'h0, m_flush});
        check("m_newpc", new_pc_o, m_newpc);
        check("m_rdata", rdata_o, ref_read(raddr_i));
    endtask

    task automatic idle_inputs();
        exception_en = 0; we_i = 0; int_i = 0; is_slot_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1; step(); rst = 0;
    endtask

    typedef struct {
        string       name;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];
    logic [31:0] etypes[7];
    logic [31:0] old;
    int pulses;
    bit found;

    initial begin
`ifdef CP0_TIMER_EN
        vecs[0] = '{"wr_count",   5'd9,  32'h0000_0055, 5'd9,  32'h0000_0055};
        vecs[1] = '{"wr_compare", 5'd11, 32'h0000_1234, 5'd11, 32'h0000_1234};
`else
        vecs[0] = '{"wr_count",   5'd9,  32'h0000_0055, 5'd9,  32'h0000_0000};
        vecs[1] = '{"wr_compare", 5'd11, 32'h0000_1234, 5'd11, 32'h0000_0000};
`endif
        vecs[2] = '{"wr_status1", 5'd12, 32'hFFFF_FFFF, 5'd12, 32'h1000_FF03};
        vecs[3] = '{"wr_status0", 5'd12, 32'h0000_0000, 5'd12, 32'h1000_0000};
        vecs[4] = '{"wr_cause",   5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0300};
        vecs[5] = '{"wr_epc",     5'd14, 32'hDEAD_BEEF, 5'd14, 32'hDEAD_BEEF};
        vecs[6] = '{"wr_prid",    5'd15, 32'h1111_1111, 5'd15, PRID_VAL};
        vecs[7] = '{"wr_unmapped",5'd3,  32'hFFFF_FFFF, 5'd3,  32'h0000_0000};
        etypes = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h77};

        // Reset and idle.
        do_reset();
        check("rst_status", status_o, 32'h1000_0000);
        check("rst_cause", cause_o, 32'h0);
        check("rst_epc", epc_o, 32'h0);
        check("rst_flush", {31'h0, flush_o}, 32'h0);
        repeat (10) step();
        raddr_i = 5'd9; #1;
`ifdef CP0_TIMER_EN
        check("count_10", rdata_o, 32'd10);
`else
        check("count_off", rdata_o, 32'd0);
`endif
        raddr_i = 5'd15; #1;
        check("prid", rdata_o, PRID_VAL);

        // Register map table.
        foreach (vecs[i]) begin
            we_i = 1; waddr_i = vecs[i].waddr; wdata_i = vecs[i].wdata; raddr_i = vecs[i].raddr;
            step();
            we_i = 0;
            check(vecs[i].name, rdata_o, vecs[i].exp);
        end
        do_reset();

        // Syscall in delay slot.
        exception_en = 1; excepttype_i = 32'h8; pc_next_i = 32'h100; is_slot_i = 1;
        step(); idle_inputs();
        check("sys_flush", {31'h0, flush_o}, 32'h1);
        check("sys_newpc", new_pc_o, 32'h20);
        check("sys_epc", epc_o, 32'h100);
        check("sys_bd", {31'h0, cause_o[31]}, 32'h1);
        check("sys_code", {27'h0, cause_o[6:2]}, 32'd8);
        check("sys_exl", {31'h0, status_o[1]}, 32'h1);
        step();
        check("sys_flush_end", {31'h0, flush_o}, 32'h0);

        // Nested exception while EXL=1, then ERET.
        exception_en = 1; excepttype_i = 32'ha; pc_next_i = 32'h200;
        step(); idle_inputs();
        check("nest_epc", epc_o, 32'h100);
        check("nest_code", {27'h0, cause_o[6:2]}, 32'd10);
        step();
        exception_en = 1; excepttype_i = 32'he;
        step(); idle_inputs();
        check("eret_flush", {31'h0, flush_o}, 32'h1);
        check("eret_newpc", new_pc_o, 32'h100);
        check("eret_exl", {31'h0, status_o[1]}, 32'h0);
        step();

        // Unknown exception type.
        exception_en = 1; excepttype_i = 32'h77; pc_next_i = 32'h180;
        step(); idle_inputs();
        check("unk_code", {27'h0, cause_o[6:2]}, 32'h1f);
        step();

        // Timer (or its absence).
`ifdef CP0_TIMER_EN
        do_reset();
        repeat (5) step();
        we_i = 1; waddr_i = 5'd11; wdata_i = 32'd20; raddr_i = 5'd9;
        step(); we_i = 0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (timer_int_o) found = 1;
        end
        check("timer_rise", {31'h0, found}, 32'h1);
        check("timer_rise_count", rdata_o, 32'd21);
        step();
        check("timer_ip7", {31'h0, cause_o[15]}, 32'h1);
        we_i = 1; waddr_i = 5'd11; wdata_i = 32'd50;
        step(); we_i = 0;
        check("timer_clear", {31'h0, timer_int_o}, 32'h0);
`else
        int_i = 6'b100000;
        step();
        check("ip7_from_int5", {31'h0, cause_o[15]}, 32'h1);
        check("timer_off", {31'h0, timer_int_o}, 32'h0);
        int_i = 0;
        step();
`endif

        // Back-to-back requests give one pulse.
        do_reset();
        pulses = 0;
        exception_en = 1; excepttype_i = 32'h1; pc_next_i = 32'h240;
        step(); if (flush_o) pulses++;
        step(); if (flush_o) pulses++;
        idle_inputs();
        step(); if (flush_o) pulses++;
        check("b2b_pulses", pulses, 32'd1);
        check("b2b_epc", epc_o, 32'h240);

        // Same-cycle WB write and exception.
        do_reset();
        raddr_i = 5'd14;
        exception_en = 1; excepttype_i = 32'hc; pc_next_i = 32'h400;
        we_i = 1; waddr_i = 5'd14; wdata_i = 32'h300;
        #1;
        check("no_bypass", rdata_o, 32'h0);
        step(); idle_inputs();
        check("wb_exc_epc", epc_o, 32'h400);
        step();
        exception_en = 1; excepttype_i = 32'he;
        we_i = 1; waddr_i = 5'd14; wdata_i = 32'h500;
        step(); idle_inputs();
        check("wb_eret_newpc", new_pc_o, 32'h400);
        check("wb_eret_epc", epc_o, 32'h500);
        step();

        // Reset during FLUSH.
        exception_en = 1; excepttype_i = 32'h8; pc_next_i = 32'h600;
        step(); idle_inputs();
        check("pre_rst_flush", {31'h0, flush_o}, 32'h1);
        rst = 1; step(); rst = 0;
        check("rst_flush_abort", {31'h0, flush_o}, 32'h0);
        check("rst_flush_status", status_o, 32'h1000_0000);
        check("rst_flush_epc", epc_o, 32'h0);
        check("rst_flush_newpc", new_pc_o, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 79) == 0);
            exception_en = ($urandom_range(0, 3) == 0);
            excepttype_i = etypes[$urandom_range(0, 6)];
            pc_next_i    = $urandom;
            is_slot_i    = $urandom_range(0, 1) == 1;
            int_i        = 6'($urandom);
            we_i         = ($urandom_range(0, 2) == 0);
            waddr_i      = 5'($urandom_range(8, 16));
            wdata_i      = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            raddr_i      = 5'($urandom_range(0, 17));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
